// File: rtl/led_indicator_pkg.sv
// Shared encodings for the LED activity indicator: display modes,
// status-LED assignments and bounce direction.
package led_indicator_pkg;

    typedef enum logic [1:0] {
        MODE_BINARY  = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_STATUS  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // STATUS mode LED slots; every slot from LED_HEARTBEAT upward is heartbeat
    localparam int LED_INIT_DONE = 0;
    localparam int LED_CAL_OK    = 1;
    localparam int LED_CAL_FAIL  = 2;
    localparam int LED_HEARTBEAT = 3;

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module bit_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/led_activity_indicator.sv
// Board LED driver: free-running counter feeding four display patterns
// (binary, bouncing scan, PWM breathe, SDRAM status) into a registered output.
module led_activity_indicator
    import led_indicator_pkg::*;
#(
    parameter int CNT_WIDTH  = 30,
    parameter int STEP_BITS  = 22,
    parameter int NUM_LEDS   = 4,
    parameter int PWM_BITS   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                clear,
    input  logic [1:0]          mode,
    input  logic                init_done,
    input  logic                cal_success,
    input  logic                cal_fail,
    output logic [NUM_LEDS-1:0] led_out
);

    localparam int POS_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int POS_MAX = NUM_LEDS - 1;
    localparam int LVL_MAX = (2 ** PWM_BITS) - 1;
    localparam logic [NUM_LEDS-1:0] LED_OFF =
        (ACTIVE_LOW != 0) ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [PWM_BITS-1:0]  level_q, level_d;
    dir_e                 dir_q, dir_d;
    mode_e                mode_q;
    logic [NUM_LEDS-1:0]  led_out_q, led_raw;

    logic init_s, cal_ok_s, cal_fail_s;
    logic step, hb;
    int   b_val;
    dir_e b_dir;

    bit_sync2 u_sync_init (.clk(clk), .reset_n(reset_n), .d_i(init_done),   .q_o(init_s));
    bit_sync2 u_sync_ok   (.clk(clk), .reset_n(reset_n), .d_i(cal_success), .q_o(cal_ok_s));
    bit_sync2 u_sync_fail (.clk(clk), .reset_n(reset_n), .d_i(cal_fail),    .q_o(cal_fail_s));

    // Triangle walk 0..max..0; turning at an end moves one unit back immediately.
    function automatic void bounce(input int val, input int max, input dir_e dir,
                                   output int nval, output dir_e ndir);
        ndir = dir;
        nval = val;
        if (max == 0) begin
            nval = 0;
        end else if (dir == DIR_UP) begin
            if (val >= max) begin
                nval = max - 1;
                ndir = DIR_DOWN;
            end else begin
                nval = val + 1;
            end
        end else begin
            if (val == 0) begin
                nval = 1;
                ndir = DIR_UP;
            end else begin
                nval = val - 1;
            end
        end
    endfunction

    always_comb begin
        step    = en & ~clear & (&cnt_q[STEP_BITS-1:0]);
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        level_d = level_q;
        dir_d   = dir_q;

        if (clear)   cnt_d = '0;
        else if (en) cnt_d = cnt_q + CNT_WIDTH'(1);

        // One bounce engine, fed by whichever pattern is on display.
        if (mode_q == MODE_SCAN) bounce(int'(pos_q), POS_MAX, dir_q, b_val, b_dir);
        else                     bounce(int'(level_q), LVL_MAX, dir_q, b_val, b_dir);

        if (clear || (mode_e'(mode) != mode_q)) begin
            pos_d   = '0;
            level_d = '0;
            dir_d   = DIR_UP;
        end else if (step && mode_q == MODE_SCAN) begin
            pos_d = POS_W'(b_val);
            dir_d = b_dir;
        end else if (step && mode_q == MODE_BREATHE) begin
            level_d = PWM_BITS'(b_val);
            dir_d   = b_dir;
        end
    end

    always_comb begin
        led_raw = '0;
        hb      = cnt_q[CNT_WIDTH-1];
        case (mode_q)
            MODE_BINARY: led_raw = cnt_q[CNT_WIDTH-1 -: NUM_LEDS];
            MODE_SCAN: begin
                for (int i = 0; i < NUM_LEDS; i++) led_raw[i] = (int'(pos_q) == i);
            end
            MODE_BREATHE: begin
                for (int i = 0; i < NUM_LEDS; i++) led_raw[i] = (cnt_q[PWM_BITS-1:0] < level_q);
            end
            MODE_STATUS: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (i == LED_INIT_DONE)     led_raw[i] = init_s;
                    else if (i == LED_CAL_OK)   led_raw[i] = cal_ok_s;
                    else if (i == LED_CAL_FAIL) led_raw[i] = cal_fail_s & hb;
                    else                        led_raw[i] = hb;
                end
            end
            default: led_raw = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            pos_q     <= '0;
            level_q   <= '0;
            dir_q     <= DIR_UP;
            mode_q    <= MODE_BINARY;
            led_out_q <= LED_OFF;
        end else begin
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            level_q   <= level_d;
            dir_q     <= dir_d;
            mode_q    <= mode_e'(mode);
            led_out_q <= led_raw ^ LED_OFF;
        end
    end

    assign led_out = led_out_q;

endmodule

// File: tb/tb_led_activity_indicator.sv
// Scoreboard bench: a step-count/triangle-wave reference model predicts the
// LED word for every clock; a monitor compares it against the registered output.
module tb_led_activity_indicator;

    localparam int CW = 8, SB = 2, NL = 4, PB = 2, AL = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0, clear = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          init_done = 1'b0, cal_success = 1'b0, cal_fail = 1'b0;
    logic [NL-1:0] led_out;

    led_activity_indicator #(
        .CNT_WIDTH(CW), .STEP_BITS(SB), .NUM_LEDS(NL), .PWM_BITS(PB), .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .mode(mode),
        .init_done(init_done), .cal_success(cal_success), .cal_fail(cal_fail),
        .led_out(led_out)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    logic        tmo_flag = 1'b0;
    logic [3:0]  exp_q[$];

    // reference state: counter value, steps taken since the pattern last restarted
    int          cnt_m = 0, nsteps = 0;
    logic [1:0]  mode_m = 2'd0;
    logic [1:0]  init_h = '0, ok_h = '0, fail_h = '0;

    function automatic int tri_wave(int n, int m);
        int t;
        if (m == 0) return 0;
        t = n % (2 * m);
        return (t <= m) ? t : 2 * m - t;
    endfunction

    function automatic logic [3:0] predict(int c, int ns, logic [1:0] md,
                                           logic s_init, logic s_ok, logic s_fail);
        logic [3:0] raw;
        logic       top;
        int         lvl;
        top = (c >= 128);
        case (md)
            2'd0: raw = 4'((c >> 4) & 15);
            2'd1: raw = 4'(1 << tri_wave(ns, NL - 1));
            2'd2: begin
                lvl = tri_wave(ns, (1 << PB) - 1);
                raw = ((c % 4) < lvl) ? 4'hF : 4'h0;
            end
            default: raw = {top, s_fail & top, s_ok, s_init};
        endcase
        return ~raw;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_m = 0; nsteps = 0; mode_m = 2'd0;
            init_h = '0; ok_h = '0; fail_h = '0;
            exp_q.delete();
            exp_q.push_back(4'hF);
        end else begin
            exp_q.push_back(predict(cnt_m, nsteps, mode_m, init_h[1], ok_h[1], fail_h[1]));
            if (clear || mode != mode_m) nsteps = 0;
            else if (en && (cnt_m % 4 == 3) && (mode_m == 2'd1 || mode_m == 2'd2)) nsteps++;
            if (clear)   cnt_m = 0;
            else if (en) cnt_m = (cnt_m + 1) % 256;
            mode_m = mode;
            init_h = {init_h[0], init_done};
            ok_h   = {ok_h[0], cal_success};
            fail_h = {fail_h[0], cal_fail};
        end
    end

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: led_out=%b expected=%b", name, $time, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clk or negedge reset_n);
        if (clk === 1'b1) begin
            #1 chk("async_reset", led_out, 4'hF);
        end else begin
            if (exp_q.size() > 0) chk("led_out", led_out, exp_q.pop_front());
            if (tmo_flag) begin
                errors++;
                tmo_flag = 1'b0;
                $display("FAIL wait_timeout at %0t: counter target not reached", $time);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset lands mid-high-phase so the output must drop without a clock edge.
    task automatic async_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_cnt(int val, int mask);
        int i;
        for (i = 0; i < 600 && ((cnt_m & mask) != val); i++) @(negedge clk);
        if ((cnt_m & mask) != val) tmo_flag = 1'b1;
    endtask

    initial begin
        tick(3);
        reset_n = 1'b1;
        en = 1'b1; mode = 2'd0;
        tick(20);
        async_reset();
        tick(300);                      // binary wrap through 256
        en = 1'b0; tick(10); en = 1'b1;

        mode = 2'd1; tick(40);
        mode = 2'd0; tick(3);
        mode = 2'd1; tick(30);

        mode = 2'd2; tick(60);
        wait_cnt(3, 3);
        clear = 1'b1; tick(1); clear = 1'b0;
        tick(40);

        mode = 2'd3; tick(5);
        init_done = 1'b1; cal_success = 1'b1; tick(10);
        cal_fail = 1'b1; tick(300);
        init_done = 1'b0; cal_success = 1'b0; tick(6);

        mode = 2'd0;
        wait_cnt(255, 255);
        clear = 1'b1; tick(1); clear = 1'b0;
        tick(10);

        mode = 2'd1; tick(9);
        wait_cnt(3, 3);
        mode = 2'd2; tick(10);
        wait_cnt(3, 3);
        mode = 2'd1; tick(20);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(499, 0) == 0) async_reset();
            en    = ($urandom_range(9, 0) != 0);
            clear = ($urandom_range(63, 0) == 0);
            if ($urandom_range(39, 0) == 0) mode = 2'($urandom_range(3, 0));
            if ($urandom_range(24, 0) == 0) init_done   = ~init_done;
            if ($urandom_range(24, 0) == 0) cal_success = ~cal_success;
            if ($urandom_range(24, 0) == 0) cal_fail    = ~cal_fail;
            tick(1);
        end
        clear = 1'b0;
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_activity_indicator.md
Name: led_activity_indicator

Overview:
- Parametrised successor to the kernel-clock LED visualiser. Drives NUM_LEDS board LEDs from a single clock domain.
- Four runtime-selectable display modes: binary count, bouncing scan, PWM breathe, and SDRAM calibration status.
- Fully synchronous counter with a step prescaler and registered, polarity-configurable outputs. Sits in top, beside the system instance, clocked by kernel_clk.

Parameters:
- CNT_WIDTH, 30, free-running counter width; must be ≥ NUM_LEDS and > STEP_BITS.
- STEP_BITS, 22, step pulse period is 2**STEP_BITS enabled cycles; must be ≥ PWM_BITS.
- NUM_LEDS, 4, number of LED outputs; must be ≥ 1.
- PWM_BITS, 4, breathe-mode duty resolution.
- ACTIVE_LOW, 1, 1 means LEDs are lit by 0 and output is inverted.

Ports:
- clk  in  1  kernel clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  count enable (synchronous to clk).
- clear  in  1  synchronous clear of counter and pattern state.
- mode  in  2  0=BINARY, 1=SCAN, 2=BREATHE, 3=STATUS.
- init_done  in  1  SDRAM init done (asynchronous; synchronised internally).
- cal_success  in  1  SDRAM calibration success (asynchronous).
- cal_fail  in  1  SDRAM calibration fail (asynchronous).
- led_out  out  NUM_LEDS  registered LED drive.

Behaviour:
- Reset (async assert, sync release): cnt=0, pos=0, dir=up, level=0, mode_q=0, synchroniser flops=0. led_out = all 1 if ACTIVE_LOW, else all 0 (LEDs off).
- cnt: increments by 1 each cycle while en=1 and clear=0. Wraps modulo 2**CNT_WIDTH. Holds while en=0.
- step: combinational. Equals en & ~clear & (cnt[STEP_BITS-1:0] == all ones), i.e. one cycle per 2**STEP_BITS enabled cycles.
- clear: takes priority over en. Next cycle cnt=0, pos=0, dir=up, level=0. mode_q is unaffected.
- mode_q: registers mode every cycle. If mode != mode_q: pos=0, dir=up, level=0 on that edge (this overrides any step in the same cycle). cnt continues.
- BINARY: led_raw = cnt[CNT_WIDTH-1 -: NUM_LEDS].
- SCAN:
  - led_raw = one-hot(pos).
  - On step with dir=up: pos+1; if pos==NUM_LEDS-1, set dir=down and pos-1.
  - On step with dir=down: pos-1; if pos==0, set dir=up and pos+1.
  - If NUM_LEDS==1, pos stays 0.
  - Sequence for 4 LEDs: 0,1,2,3,2,1,0,1,...
- BREATHE:
  - level (PWM_BITS wide) bounces 0 → 2**PWM_BITS-1 → 0, one unit per step, using dir the same way as SCAN.
  - Every LED: led_raw[i] = (cnt[PWM_BITS-1:0] < level). level=0 means fully off.
  - With en=0 the phase is frozen, so LEDs hold at a steady value.
- STATUS:
  - led_raw[0] = init_done_s.
  - led_raw[1] = cal_success_s.
  - led_raw[2] = cal_fail_s & cnt[CNT_WIDTH-1] (blinks).
  - led_raw[3..NUM_LEDS-1] = cnt[CNT_WIDTH-1] (heartbeat).
  - Indices ≥ NUM_LEDS are dropped.
  - The _s signals come from 2-flop synchronisers, giving 2 cycles of input latency.
- Output: led_out <= ACTIVE_LOW ? ~led_raw : led_raw. One cycle after the state it reflects.
- Combinational pattern logic uses registered mode_q, not raw mode.

Decomposition:
- Package led_indicator_pkg: mode encodings (MODE_BINARY, MODE_SCAN, MODE_BREATHE, MODE_STATUS), status LED index constants, dir encoding.
- One sub-module: bit_sync2, a 2-flop synchroniser, instantiated 3× for the status inputs. It is reset by reset_n.
- The bounce (pos/level up-down) update is shared combinational logic inside the top-level module, not a separate module.

Test Plan:
Bench parameters: CNT_WIDTH=8, STEP_BITS=2, NUM_LEDS=4, PWM_BITS=2, ACTIVE_LOW=1.
- Reset: reset_n=0 mid-run, asynchronously → led_out=4'b1111 immediately, cnt=0. After release with en=1, mode=0: after 16 cycles, led_out=~4'b0001 (cnt=16 → top nibble 1).
- BINARY wrap: run 256 enabled cycles → cnt wraps to 0 and led_out returns to 4'b1111. Deassert en for 10 cycles → led_out unchanged.
- SCAN: mode=1, en=1, steps every 4 cycles → lit index goes 0,1,2,3,2,1,0,1. led_out goes 1110,1101,1011,0111,1011,... Switch mode 1→0→1 → pos restarts at 0.
- BREATHE: mode=2, level goes 0,1,2,3,2,... Check the lit-cycle count per 4-cycle PWM window equals level (0,1,2,3,2). Assert clear and step together → level=0 next cycle.
- STATUS: mode=3; assert init_done=1 and cal_success=1 async → led_out[1:0]=00 exactly 3 cycles later (2 sync + 1 out). cal_fail=1 → led_out[2] toggles in phase with cnt[7]. led_out[3] = ~cnt[7].
- Simultaneous events: clear=1 with en=1 at cnt=8'hFF → cnt=0 next cycle, not wrapping via increment. Mode change on a step cycle → pos=0, not advanced.
